usq_next_addr: RTL and testbench

//  Micro-sequencer next-address unit: consumer of the wired-AND CS ADDR branch

---
 rtl/usq_next_addr_if.sv | 35 +++
 rtl/usq_next_addr.sv | 115 +++++++++++
 tb/tb_usq_next_addr.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/usq_next_addr_if.sv
// Bundle of the next-address unit's microword, branch, stack-control and status signals.
// The master side drives the controls and the slave side is the sequencer.
interface usq_next_addr_if #(
  parameter int ADDR_W    = 14,
  parameter int STK_DEPTH = 8
);
  localparam int DEP_W = $clog2(STK_DEPTH) + 1;

  logic              d_clk_enable_h;
  logic [ADDR_W-1:0] nxt_addr_h;
  logic [5:0]        cs_addr_l;
  logic              dis_cs_addr_h;
  logic              call_h;
  logic [ADDR_W-1:0] ret_addr_h;
  logic              ret_h;
  logic              trap_h;
  logic [ADDR_W-1:0] trap_vec_h;
  logic              stk_err_clr_h;
  logic [ADDR_W-1:0] upc_h;
  logic [DEP_W-1:0]  stk_depth_h;
  logic              stk_ovf_h;
  logic              stk_unf_h;

  modport master (
    output d_clk_enable_h, nxt_addr_h, cs_addr_l, dis_cs_addr_h, call_h, ret_addr_h,
           ret_h, trap_h, trap_vec_h, stk_err_clr_h,
    input  upc_h, stk_depth_h, stk_ovf_h, stk_unf_h
  );

  modport slave (
    input  d_clk_enable_h, nxt_addr_h, cs_addr_l, dis_cs_addr_h, call_h, ret_addr_h,
           ret_h, trap_h, trap_vec_h, stk_err_clr_h,
    output upc_h, stk_depth_h, stk_ovf_h, stk_unf_h
  );
endinterface

// File: rtl/usq_next_addr.sv
// Micro-sequencer next-address unit: merges NXT, BUT branch bits, the return stack and
// microtrap vectors into the registered micro-PC.
module usq_next_addr #(
  parameter int                ADDR_W    = 14,
  parameter int                STK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input logic          buf_m_clk_l,
  input logic          sac_reset_l,
  usq_next_addr_if.slave bus
);
  localparam int PTR_W = $clog2(STK_DEPTH);
  localparam int DEP_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [DEP_W-1:0] DEP_ONE  = DEP_W'(1);
  localparam logic [DEP_W-1:0] DEP_FULL = DEP_W'(STK_DEPTH);

  // ptr_p1 is the next free slot; the top entry sits at ptr_p1-1.
  logic [ADDR_W-1:0] upc_p1;
  logic [PTR_W-1:0]  ptr_p1;
  logic [DEP_W-1:0]  depth_p1;
  logic              ovf_p1;
  logic              unf_p1;
  logic [ADDR_W-1:0] stk [STK_DEPTH];

  logic [5:0]        br;
  logic [ADDR_W-1:0] br_ext;
  logic [ADDR_W-1:0] top;
  logic              empty;
  logic              full;
  logic [ADDR_W-1:0] upc_nxt;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [DEP_W-1:0]  depth_nxt;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_data;
  logic              ovf_set;
  logic              unf_set;

  always_comb begin
    br        = bus.dis_cs_addr_h ? 6'b0 : ~bus.cs_addr_l;
    br_ext    = {{(ADDR_W-6){1'b0}}, br};
    empty     = (depth_p1 == '0);
    full      = (depth_p1 == DEP_FULL);
    top       = empty ? '0 : stk[ptr_p1 - PTR_ONE];
    upc_nxt   = bus.nxt_addr_h | br_ext;
    ptr_nxt   = ptr_p1;
    depth_nxt = depth_p1;
    wr_en     = 1'b0;
    wr_idx    = ptr_p1;
    wr_data   = bus.ret_addr_h;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (bus.trap_h) begin
      // Trap target is taken verbatim; the interrupted micro-PC is saved.
      upc_nxt   = bus.trap_vec_h;
      wr_en     = 1'b1;
      wr_data   = upc_p1;
      ptr_nxt   = ptr_p1 + PTR_ONE;
      depth_nxt = full ? depth_p1 : depth_p1 + DEP_ONE;
      ovf_set   = full;
    end else if (bus.ret_h && bus.call_h) begin
      upc_nxt = top | br_ext;
      wr_en   = 1'b1;
      if (empty) begin
        ptr_nxt   = ptr_p1 + PTR_ONE;
        depth_nxt = DEP_ONE;
        unf_set   = 1'b1;
      end else begin
        wr_idx = ptr_p1 - PTR_ONE;
      end
    end else if (bus.ret_h) begin
      upc_nxt = top | br_ext;
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        ptr_nxt   = ptr_p1 - PTR_ONE;
        depth_nxt = depth_p1 - DEP_ONE;
      end
    end else if (bus.call_h) begin
      wr_en     = 1'b1;
      ptr_nxt   = ptr_p1 + PTR_ONE;
      depth_nxt = full ? depth_p1 : depth_p1 + DEP_ONE;
      ovf_set   = full;
    end
  end

  // Stage p1: registered micro-PC and stack control
  always_ff @(posedge buf_m_clk_l or negedge sac_reset_l) begin
    if (!sac_reset_l) begin
      upc_p1   <= RESET_VEC;
      ptr_p1   <= '0;
      depth_p1 <= '0;
      ovf_p1   <= 1'b0;
      unf_p1   <= 1'b0;
    end else if (bus.d_clk_enable_h) begin
      upc_p1   <= upc_nxt;
      ptr_p1   <= ptr_nxt;
      depth_p1 <= depth_nxt;
      ovf_p1   <= ovf_set | (ovf_p1 & ~bus.stk_err_clr_h);
      unf_p1   <= unf_set | (unf_p1 & ~bus.stk_err_clr_h);
    end
  end

  always_ff @(posedge buf_m_clk_l) begin
    if (bus.d_clk_enable_h && wr_en) begin
      stk[wr_idx] <= wr_data;
    end
  end

  assign bus.upc_h       = upc_p1;
  assign bus.stk_depth_h = depth_p1;
  assign bus.stk_ovf_h   = ovf_p1;
  assign bus.stk_unf_h   = unf_p1;
endmodule

// File: tb/tb_usq_next_addr.sv
// Directed bench for usq_next_addr: expected micro-PC/stack state is queued as each step
// is driven and compared after the clock edge that produces it.
module tb_usq_next_addr;
  localparam int ADDR_W = 14;
  localparam int STK_DEPTH = 8;
  localparam int DEP_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] upc;
    logic [DEP_W-1:0]  depth;
    logic              ovf;
    logic              unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  usq_next_addr_if #(.ADDR_W(ADDR_W), .STK_DEPTH(STK_DEPTH)) bus ();

  usq_next_addr #(.ADDR_W(ADDR_W), .STK_DEPTH(STK_DEPTH), .RESET_VEC('0)) dut (
    .buf_m_clk_l(clk),
    .sac_reset_l(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".upc"},   32'(bus.upc_h),       32'(e.upc));
    chk({tag, ".depth"}, 32'(bus.stk_depth_h), 32'(e.depth));
    chk({tag, ".ovf"},   32'(bus.stk_ovf_h),   32'(e.ovf));
    chk({tag, ".unf"},   32'(bus.stk_unf_h),   32'(e.unf));
  endtask

  // Drive one cycle of inputs, queue its expected outcome, clock, then pop and compare.
  task automatic step(input string tag, input logic en, input logic [ADDR_W-1:0] nxt,
                      input logic [5:0] csl, input logic dis, input logic call,
                      input logic [ADDR_W-1:0] ra, input logic ret, input logic trap,
                      input logic [ADDR_W-1:0] tv, input logic clr,
                      input logic [ADDR_W-1:0] e_upc, input logic [DEP_W-1:0] e_dep,
                      input logic e_ovf, input logic e_unf);
    exp_t e;
    bus.d_clk_enable_h = en;
    bus.nxt_addr_h     = nxt;
    bus.cs_addr_l      = csl;
    bus.dis_cs_addr_h  = dis;
    bus.call_h         = call;
    bus.ret_addr_h     = ra;
    bus.ret_h          = ret;
    bus.trap_h         = trap;
    bus.trap_vec_h     = tv;
    bus.stk_err_clr_h  = clr;
    sb.push_back('{upc: e_upc, depth: e_dep, ovf: e_ovf, unf: e_unf});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk_state(tag, e);
    end
  endtask

  initial begin
    bus.d_clk_enable_h = 1'b0;
    bus.nxt_addr_h     = '0;
    bus.cs_addr_l      = 6'h3F;
    bus.dis_cs_addr_h  = 1'b0;
    bus.call_h         = 1'b0;
    bus.ret_addr_h     = '0;
    bus.ret_h          = 1'b0;
    bus.trap_h         = 1'b0;
    bus.trap_vec_h     = '0;
    bus.stk_err_clr_h  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", '{upc: 14'h0, depth: 4'd0, ovf: 1'b0, unf: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // T1: build upc=0x123 with depth 3, then reset asynchronously mid-cycle
    step("t1_c0", 1, 14'h100, 6'h3F, 0, 1, 14'h0A0, 0, 0, 14'h0, 0, 14'h100, 4'd1, 0, 0);
    step("t1_c1", 1, 14'h110, 6'h3F, 0, 1, 14'h0A1, 0, 0, 14'h0, 0, 14'h110, 4'd2, 0, 0);
    step("t1_c2", 1, 14'h123, 6'h3F, 0, 1, 14'h0A2, 0, 0, 14'h0, 0, 14'h123, 4'd3, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_state("t1_async", '{upc: 14'h0, depth: 4'd0, ovf: 1'b0, unf: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // T2: branch merge and disable
    step("t2_br",  1, 14'h0340, 6'b111010, 0, 0, 14'h0, 0, 0, 14'h0, 0, 14'h0345, 4'd0, 0, 0);
    step("t2_dis", 1, 14'h0340, 6'b111010, 1, 0, 14'h0, 0, 0, 14'h0, 0, 14'h0340, 4'd0, 0, 0);

    // T3: call then return with branch bit 0
    step("t3_call", 1, 14'h0500, 6'h3F, 0, 1, 14'h0200, 0, 0, 14'h0, 0, 14'h0500, 4'd1, 0, 0);
    step("t3_ret",  1, 14'h0000, 6'b111110, 0, 0, 14'h0, 1, 0, 14'h0, 0, 14'h0201, 4'd0, 0, 0);

    // T4: overflow on the ninth call, unwind, underflow on the ninth return
    for (int i = 0; i < 9; i++) begin
      step("t4_call", 1, 14'(14'h600 + i), 6'h3F, 0, 1, 14'(14'h10 + i), 0, 0, 14'h0, 0,
           14'(14'h600 + i), (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 0);
    end
    for (int i = 0; i < 8; i++) begin
      step("t4_ret", 1, 14'h0, 6'h3F, 0, 0, 14'h0, 1, 0, 14'h0, 0,
           14'(14'h18 - i), 4'(7 - i), 1, 0);
    end
    step("t4_unf", 1, 14'h0, 6'b110011, 0, 0, 14'h0, 1, 0, 14'h0, 0, 14'h000C, 4'd0, 1, 1);
    step("t4_clr", 1, 14'h050, 6'h3F, 0, 0, 14'h0, 0, 0, 14'h0, 1, 14'h0050, 4'd0, 0, 0);
    step("t4_setwin", 1, 14'h0, 6'h3F, 0, 0, 14'h0, 1, 0, 14'h0, 1, 14'h0000, 4'd0, 0, 1);
    step("t4_clr2", 1, 14'h051, 6'h3F, 0, 0, 14'h0, 0, 0, 14'h0, 1, 14'h0051, 4'd0, 0, 0);

    // T5: trap beats call/ret and ignores branch bits; saved upc pops back
    step("t5_call", 1, 14'h0077, 6'h3F, 0, 1, 14'h0300, 0, 0, 14'h0, 0, 14'h0077, 4'd1, 0, 0);
    step("t5_trap", 1, 14'h0111, 6'h00, 0, 1, 14'h0222, 1, 1, 14'h3F00, 0, 14'h3F00, 4'd2, 0, 0);
    step("t5_ret1", 1, 14'h0, 6'h3F, 0, 0, 14'h0, 1, 0, 14'h0, 0, 14'h0077, 4'd1, 0, 0);
    step("t5_ret2", 1, 14'h0, 6'h3F, 0, 0, 14'h0, 1, 0, 14'h0, 0, 14'h0300, 4'd0, 0, 0);

    // RET+CALL on a non-empty and on an empty stack
    step("rc_call", 1, 14'h0020, 6'h3F, 0, 1, 14'h0400, 0, 0, 14'h0, 0, 14'h0020, 4'd1, 0, 0);
    step("rc_swap", 1, 14'h0, 6'h3F, 0, 1, 14'h0410, 1, 0, 14'h0, 0, 14'h0400, 4'd1, 0, 0);
    step("rc_ret",  1, 14'h0, 6'h3F, 0, 0, 14'h0, 1, 0, 14'h0, 0, 14'h0410, 4'd0, 0, 0);
    step("rc_empty", 1, 14'h0, 6'b111100, 0, 1, 14'h0420, 1, 0, 14'h0, 0, 14'h0003, 4'd1, 0, 1);
    step("rc_ret2", 1, 14'h0, 6'h3F, 0, 0, 14'h0, 1, 0, 14'h0, 0, 14'h0420, 4'd0, 0, 1);
    step("rc_clr",  1, 14'h0AB, 6'h3F, 0, 1, 14'h0111, 0, 0, 14'h0, 1, 14'h00AB, 4'd1, 0, 0);

    // T6: enable low holds everything despite call/trap/clear
    for (int i = 0; i < 4; i++) begin
      step("t6_hold", 0, 14'h0555, 6'h00, 0, 1, 14'h0666, 0, 1, 14'h3ABC, 1,
           14'h00AB, 4'd1, 0, 0);
    end
    step("t6_ret", 1, 14'h0, 6'h3F, 0, 0, 14'h0, 1, 0, 14'h0, 0, 14'h0111, 4'd0, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
